pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 40 ++++
 rtl/pipe_perf_cnt.sv | 25 ++
 rtl/pipe_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: FSM states, stage indices and stage-mask helpers.
package pipe_ctrl_pkg;

  localparam int unsigned NUM_STAGES  = 5;
  localparam int unsigned PIPE_PC     = 0;
  localparam int unsigned PIPE_IF_ID  = 1;
  localparam int unsigned PIPE_ID_EX  = 2;
  localparam int unsigned PIPE_EX_MEM = 3;
  localparam int unsigned PIPE_MEM_WB = 4;
  localparam int unsigned PERF_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  typedef logic [NUM_STAGES-1:0] stage_vec_t;

  // One-hot mask selecting a single pipeline register.
  function automatic stage_vec_t stage_bit(input int unsigned s);
    stage_vec_t m;
    m = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (i == s) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Mask of every register upstream of stage s (those held while s takes a bubble).
  function automatic stage_vec_t stages_below(input int unsigned s);
    stage_vec_t m;
    m = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (i < s) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Enabled saturating event counter; compiled only when PIPE_CTRL_PERF_EN is defined.
`ifdef PIPE_CTRL_PERF_EN
module pipe_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-register pause/flush and PC redirect generation.
// Optional PIPE_CTRL_PERF_EN adds saturating stall and redirect counters.
`ifndef XLEN
`define XLEN 32
`endif

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = `XLEN,
  parameter int unsigned INIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_busy,
  input  logic            ex_busy,
  input  logic            ld_use,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic [4:0]      pause,
  output logic [4:0]      flush,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_target
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   pend_q, pend_d;
  logic              busy;

  assign busy = mem_busy | ex_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pause       = '0;
    flush       = '0;
    pc_redirect = 1'b0;
    pc_target   = '0;

    // A busy stage takes a bubble in the register after it and holds everything upstream.
    if (state_q != ST_INIT) begin
      if (mem_busy) begin
        pause = stages_below(PIPE_MEM_WB);
        flush = stage_bit(PIPE_MEM_WB);
      end else if (ex_busy) begin
        pause = stages_below(PIPE_EX_MEM);
        flush = stage_bit(PIPE_EX_MEM);
      end
    end

    unique case (state_q)
      ST_INIT: begin
        pause = stage_bit(PIPE_PC);
        flush = ~stage_bit(PIPE_PC);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == INIT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (busy) begin
          if (br_taken) begin
            pend_d  = br_target;
            state_d = ST_PEND;
          end
        end else if (br_taken) begin
          flush       = stage_bit(PIPE_IF_ID) | stage_bit(PIPE_ID_EX);
          pc_redirect = 1'b1;
          pc_target   = br_target;
        end else if (ld_use) begin
          pause = stages_below(PIPE_ID_EX);
          flush = stage_bit(PIPE_ID_EX);
        end
      end
      ST_PEND: begin
        // br_taken here is the replay of the branch already held in pend_q.
        if (!busy) begin
          flush       = stage_bit(PIPE_IF_ID) | stage_bit(PIPE_ID_EX);
          pc_redirect = 1'b1;
          pc_target   = pend_q;
          state_d     = ST_RUN;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt #(.W(PERF_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  ((state_q != ST_INIT) && (|pause)),
    .cnt_o (stall_cnt)
  );

  pipe_perf_cnt #(.W(PERF_CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (pc_redirect),
    .cnt_o (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, multi-cycle corner
// sequences and a randomized run against a rule-level reference model.
module tb_pipe_ctrl;

  localparam int unsigned INIT_CYCLES = 2;
  localparam int unsigned N_RAND      = 1500;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_busy, ex_busy, ld_use, br_taken;
  logic [31:0] br_target;
  logic [4:0]  pause, flush;
  logic        pc_redirect;
  logic [31:0] pc_target;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  pipe_ctrl #(.XLEN(32), .INIT_CYCLES(INIT_CYCLES)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_busy    (mem_busy),
    .ex_busy     (ex_busy),
    .ld_use      (ld_use),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .pause       (pause),
    .flush       (flush),
    .pc_redirect (pc_redirect),
    .pc_target   (pc_target)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        mb, eb, lu, bt;
    logic [31:0] tgt;
    logic [4:0]  ep, ef;
    logic        er;
    logic [31:0] et;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [4:0] ep, input logic [4:0] ef,
                         input logic er, input logic [31:0] et);
    chk({name, ".pause"},       32'(pause),       32'(ep));
    chk({name, ".flush"},       32'(flush),       32'(ef));
    chk({name, ".pc_redirect"}, 32'(pc_redirect), 32'(er));
    chk({name, ".pc_target"},   pc_target,        et);
  endtask

  task automatic drive(input logic mb, input logic eb, input logic lu, input logic bt,
                       input logic [31:0] tgt);
    mem_busy  = mb;
    ex_busy   = eb;
    ld_use    = lu;
    br_taken  = bt;
    br_target = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[9];

  // Reference model state, expressed as the spec's rules rather than FSM encoding
  int          init_left;
  bit          has_pend;
  logic [31:0] pend_tgt;
  logic [4:0]  ep, ef;
  logic        er;
  logic [31:0] et;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         5'b00011, 5'b00100, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         5'b00000, 5'b00000, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0040, 5'b00000, 5'b00110, 1'b1, 32'h8000_0040};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_1234, 5'b00000, 5'b00110, 1'b1, 32'h0000_1234};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         5'b01111, 5'b10000, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         5'b00111, 5'b01000, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         5'b01111, 5'b10000, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         5'b00111, 5'b01000, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hffff_ffff, 5'b00000, 5'b00000, 1'b0, 32'h0};

    // Reset held two cycles, then exactly INIT_CYCLES flush cycles
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    @(negedge clk);
    chk_out("reset", 5'b00001, 5'b11110, 1'b0, 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < int'(INIT_CYCLES); i++) begin
      @(negedge clk);
      chk_out($sformatf("init%0d", i), 5'b00001, 5'b11110, 1'b0, 32'h0);
      step();
    end
    @(negedge clk);
    chk_out("run_idle", 5'b00000, 5'b00000, 1'b0, 32'h0);

    // Single-cycle RUN decisions
    for (int i = 0; i < 9; i++) begin
      step();
      drive(vecs[i].mb, vecs[i].eb, vecs[i].lu, vecs[i].bt, vecs[i].tgt);
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), vecs[i].ep, vecs[i].ef, vecs[i].er, vecs[i].et);
    end

    // Branch under mem_busy is deferred; a replayed pulse in PEND is ignored
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
    @(negedge clk);
    chk_out("pend_c0", 5'b01111, 5'b10000, 1'b0, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      step();
      drive(1'b1, 1'b0, 1'b0, (c == 2), 32'hdead_beef);
      @(negedge clk);
      chk_out($sformatf("pend_c%0d", c), 5'b01111, 5'b10000, 1'b0, 32'h0);
    end
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk_out("pend_c4", 5'b00000, 5'b00110, 1'b1, 32'h100);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk_out("pend_after", 5'b00000, 5'b00000, 1'b0, 32'h0);

    // Branch under ex_busy, then reset mid-PEND discards the pending redirect
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
    @(negedge clk);
    chk_out("expend_c0", 5'b00111, 5'b01000, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    chk_out("rst_in_pend", 5'b00001, 5'b11110, 1'b0, 32'h0);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < int'(INIT_CYCLES) + 4; c++) begin
      @(negedge clk);
      chk($sformatf("no_redirect%0d", c), 32'(pc_redirect), 32'h0);
      step();
    end

    // Randomized run against the reference model
    rst       = 1'b1;
    init_left = int'(INIT_CYCLES);
    has_pend  = 1'b0;
    pend_tgt  = 32'h0;
    @(negedge clk);
    chk_out("rand_rst", 5'b00001, 5'b11110, 1'b0, 32'h0);
    for (int n = 0; n < int'(N_RAND); n++) begin
      step();
      rst = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), $urandom);
      if (rst) begin
        init_left = int'(INIT_CYCLES);
        has_pend  = 1'b0;
      end
      @(negedge clk);
      ep = 5'b0; ef = 5'b0; er = 1'b0; et = 32'h0;
      if (rst || init_left > 0) begin
        ep = 5'b00001; ef = 5'b11110;
      end else if (mem_busy) begin
        ep = 5'b01111; ef = 5'b10000;
      end else if (ex_busy) begin
        ep = 5'b00111; ef = 5'b01000;
      end else if (has_pend) begin
        ef = 5'b00110; er = 1'b1; et = pend_tgt;
      end else if (br_taken) begin
        ef = 5'b00110; er = 1'b1; et = br_target;
      end else if (ld_use) begin
        ep = 5'b00011; ef = 5'b00100;
      end
      chk_out($sformatf("rand%0d", n), ep, ef, er, et);
      chk($sformatf("rand%0d.overlap", n), 32'(pause & flush), 32'h0);
      if (!rst) begin
        if (init_left > 0) begin
          init_left--;
        end else if (mem_busy || ex_busy) begin
          if (!has_pend && br_taken) begin
            has_pend = 1'b1;
            pend_tgt = br_target;
          end
        end else begin
          has_pend = 1'b0;
        end
      end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Three load-use stalls and one redirect after a fresh reset
    step();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("perf_rst.stall_cnt", stall_cnt, 32'h0);
    chk("perf_rst.flush_cnt", flush_cnt, 32'h0);
    step();
    rst = 1'b0;
    for (int c = 0; c < int'(INIT_CYCLES); c++) step();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h40);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    @(negedge clk);
    chk("perf.stall_cnt", stall_cnt, 32'd3);
    chk("perf.flush_cnt", flush_cnt, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
